branch_target_predictor: RTL and testbench
==========================================

Name: branch_target_predictor

Overview:
- Parametrised successor to the single-bit, PC-indexed branch predictor used by the ID stage.
- Direct-mapped branch target buffer (BTB) with tagged entries, N-bit saturating direction counters and stored targets, so fetch can redirect without decoding the immediate.
- Lookup is combinational from registered state; training comes from the EX-stage branch/jump resolution; a performance counter tracks mispredictions.

Parameters:
- XLEN, 32, PC/target width.
- ENTRIES, 16, table depth; power of two, ≥2; IDX_W = log2(ENTRIES).
- TAG_W, 8, tag bits stored per entry; requires IDX_W+TAG_W+2 ≤ XLEN.
- CNT_W, 2, saturating counter width (1..4).

Ports:
- clk  input  1  clock.
- reset  input  1  asynchronous, active-high reset.
- lookup_pc  input  XLEN  PC being predicted.
- pred_hit  output  1  valid entry with matching tag.
- pred_taken  output  1  predict taken.
- pred_target  output  XLEN  predicted next PC.
- upd_valid  input  1  resolution update this cycle.
- upd_pc  input  XLEN  PC of the resolved instruction.
- upd_taken  input  1  actual outcome.
- upd_target  input  XLEN  actual taken target.
- upd_is_jump  input  1  unconditional JAL/JALR.
- upd_mispredict  input  1  EX detected a misprediction.
- flush_all  input  1  synchronous invalidate of all entries.
- perf_mispredicts  output  32  saturating misprediction count.

Behaviour:
- Field mapping: idx = pc[IDX_W+1:2]; tag = pc[IDX_W+TAG_W+1:IDX_W+2]; pc[1:0] ignored.
- Entry contents: valid, tag, target[XLEN-1:0], cnt[CNT_W-1:0].
- Lookup (combinational, 0 cycles): pred_hit = valid[idx] && tag match.
  - pred_taken = pred_hit && cnt MSB.
  - pred_target = stored target when pred_taken, else lookup_pc+4 (mod 2^XLEN).
- Update (on posedge when upd_valid):
  - Hit, upd_is_jump: cnt = all-ones; target = upd_target.
  - Hit, taken: cnt saturating +1; target = upd_target.
  - Hit, not taken: cnt saturating -1; target unchanged.
  - Miss, taken or jump: allocate (overwrite) entry at idx; valid = 1, tag, target = upd_target; cnt = all-ones for a jump, else 2^(CNT_W-1) (weakly taken).
  - Miss, not taken: no state change.
- No read/write bypass: a same-cycle update to the looked-up index becomes visible on the cycle after the edge.
- flush_all clears every valid bit on the next edge; targets and counters are don't-care. flush_all wins over a simultaneous upd_valid.
- perf_mispredicts:
  - Increments on each edge with upd_valid && upd_mispredict.
  - Saturates at 0xFFFF_FFFF.
  - Unaffected by flush_all; cleared only by reset.
- Reset (async): all valid = 0, cnt = 0, targets = 0, perf_mispredicts = 0.
  - Outputs during/after reset: pred_hit = 0, pred_taken = 0, pred_target = lookup_pc+4.
  - Reset asserted mid-update discards that update.
- CNT_W = 1 degenerates to last-outcome prediction; all rules above still apply.

Test Plan:
- Reset, lookup_pc = 0x40 -> pred_hit = 0, pred_taken = 0, pred_target = 0x44, perf_mispredicts = 0.
- Update pc 0x40, taken, target 0x100 (cnt = 2'b10) -> next cycle lookup 0x40 gives hit = 1, taken = 1, target = 0x100. Two not-taken updates -> taken = 0, target = 0x44, hit = 1. Three more not-taken -> cnt stays 0.
- Alias: entry at 0x40 (idx 0, tag 0x01); lookup 0x440 (idx 0, tag 0x11) -> hit = 0. Taken update at 0x440 -> 0x440 hits; 0x40 now misses.
- Same-cycle update and lookup of 0x80 -> pred_hit = 0 that cycle, 1 the next cycle. flush_all together with an update -> both 0x40 and 0x80 miss afterwards.
- JAL update pc 0x200 target 0x300, miss -> cnt = 2'b11. One not-taken update -> still predicts taken.
- Five upd_mispredict pulses, one with upd_valid = 0 -> perf_mispredicts = 4. Force counter to 0xFFFF_FFFF, pulse -> stays 0xFFFF_FFFF. Async reset mid-cycle -> 0 immediately.

Source files
------------

// File: rtl/branch_target_predictor.sv
// Direct-mapped, tagged branch target buffer with saturating direction counters.
// Lookup is combinational from registered state; EX-stage resolutions train it.
module branch_target_predictor #(
  parameter int XLEN    = 32,
  parameter int ENTRIES = 16,
  parameter int TAG_W   = 8,
  parameter int CNT_W   = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [XLEN-1:0] lookup_pc,
  output logic            pred_hit,
  output logic            pred_taken,
  output logic [XLEN-1:0] pred_target,
  input  logic            upd_valid,
  input  logic [XLEN-1:0] upd_pc,
  input  logic            upd_taken,
  input  logic [XLEN-1:0] upd_target,
  input  logic            upd_is_jump,
  input  logic            upd_mispredict,
  input  logic            flush_all,
  output logic [31:0]     perf_mispredicts
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] CNT_WEAK = CNT_W'(1) << (CNT_W - 1);

  logic [ENTRIES-1:0] valid;
  logic [TAG_W-1:0]   tag_mem    [ENTRIES];
  logic [XLEN-1:0]    target_mem [ENTRIES];
  logic [CNT_W-1:0]   cnt_mem    [ENTRIES];

  // Only the index and tag fields of each PC are looked at; the rest alias.
  logic [IDX_W-1:0] lk_idx, up_idx;
  logic [TAG_W-1:0] lk_tag, up_tag;
  logic             up_hit;
  logic             unused_pc_bits;

  assign lk_idx = lookup_pc[IDX_W+1:2];
  assign lk_tag = lookup_pc[IDX_W+TAG_W+1:IDX_W+2];
  assign up_idx = upd_pc[IDX_W+1:2];
  assign up_tag = upd_pc[IDX_W+TAG_W+1:IDX_W+2];
  assign unused_pc_bits = &{1'b0, lookup_pc, upd_pc};

  assign pred_hit    = valid[lk_idx] && (tag_mem[lk_idx] == lk_tag);
  assign pred_taken  = pred_hit && cnt_mem[lk_idx][CNT_W-1];
  assign pred_target = pred_taken ? target_mem[lk_idx] : lookup_pc + XLEN'(4);

  assign up_hit = valid[up_idx] && (tag_mem[up_idx] == up_tag);

  logic             wr_en;
  logic [CNT_W-1:0] wr_cnt;
  logic [XLEN-1:0]  wr_target;
  logic [CNT_W-1:0] cur_cnt;

  assign cur_cnt = cnt_mem[up_idx];

  always_comb begin
    // NOTE: every output of this block gets a default first so no latch is inferred.
    wr_en     = 1'b0;
    wr_cnt    = cur_cnt;
    wr_target = target_mem[up_idx];
    if (upd_valid) begin
      if (up_hit) begin
        wr_en = 1'b1;
        if (upd_is_jump) begin
          wr_cnt    = CNT_MAX;
          wr_target = upd_target;
        end else if (upd_taken) begin
          wr_cnt    = (cur_cnt == CNT_MAX) ? cur_cnt : cur_cnt + CNT_W'(1);
          wr_target = upd_target;
        end else begin
          wr_cnt = (cur_cnt == '0) ? cur_cnt : cur_cnt - CNT_W'(1);
        end
      end else if (upd_taken || upd_is_jump) begin
        // Miss on a taken branch or jump: allocate over whatever lives at idx.
        wr_en     = 1'b1;
        wr_target = upd_target;
        wr_cnt    = upd_is_jump ? CNT_MAX : CNT_WEAK;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid <= '0;
      // NOTE: the table is small and lives in flops, so reset clears it explicitly.
      for (int i = 0; i < ENTRIES; i++) begin
        tag_mem[i]    <= '0;
        target_mem[i] <= '0;
        cnt_mem[i]    <= '0;
      end
    end else if (flush_all) begin
      valid <= '0;
    end else if (wr_en) begin
      // NOTE: state is updated with non-blocking assignments so every reader sees pre-edge values.
      valid[up_idx]      <= 1'b1;
      tag_mem[up_idx]    <= up_tag;
      target_mem[up_idx] <= wr_target;
      cnt_mem[up_idx]    <= wr_cnt;
    end
  end

  // Misprediction count survives flushes and sticks at all-ones.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_mispredicts <= '0;
    end else if (upd_valid && upd_mispredict && (perf_mispredicts != '1)) begin
      perf_mispredicts <= perf_mispredicts + 32'd1;
    end
  end

endmodule

// File: tb/tb_branch_target_predictor.sv
// Scoreboard bench for branch_target_predictor: a driver pushes model predictions,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_branch_target_predictor;

  localparam int XLEN    = 32;
  localparam int ENTRIES = 16;
  localparam int TAG_W   = 8;
  localparam int CNT_W   = 2;
  localparam int CMAX    = (1 << CNT_W) - 1;
  localparam int CWEAK   = 1 << (CNT_W - 1);

  logic            clk = 1'b1;
  logic            reset;
  logic [XLEN-1:0] lookup_pc;
  logic            pred_hit;
  logic            pred_taken;
  logic [XLEN-1:0] pred_target;
  logic            upd_valid;
  logic [XLEN-1:0] upd_pc;
  logic            upd_taken;
  logic [XLEN-1:0] upd_target;
  logic            upd_is_jump;
  logic            upd_mispredict;
  logic            flush_all;
  logic [31:0]     perf_mispredicts;

  branch_target_predictor #(
    .XLEN(XLEN), .ENTRIES(ENTRIES), .TAG_W(TAG_W), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .reset(reset), .lookup_pc(lookup_pc),
    .pred_hit(pred_hit), .pred_taken(pred_taken), .pred_target(pred_target),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken),
    .upd_target(upd_target), .upd_is_jump(upd_is_jump),
    .upd_mispredict(upd_mispredict), .flush_all(flush_all),
    .perf_mispredicts(perf_mispredicts)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    bit          hit;
    bit          taken;
    logic [31:0] target;
    logic [31:0] perf;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, req);
    end
  endtask

  // Reference model: the table as plain arrays, indexed by PC arithmetic.
  bit          m_valid [ENTRIES];
  int unsigned m_tag   [ENTRIES];
  logic [31:0] m_tgt   [ENTRIES];
  int          m_cnt   [ENTRIES];
  longint      m_perf;

  function automatic int unsigned idx_of(input logic [31:0] pc);
    return (pc / 4) % ENTRIES;
  endfunction

  function automatic int unsigned tag_of(input logic [31:0] pc);
    return (pc / (4 * ENTRIES)) % (1 << TAG_W);
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < ENTRIES; i++) begin
      m_valid[i] = 0; m_tag[i] = 0; m_tgt[i] = 0; m_cnt[i] = 0;
    end
    m_perf = 0;
  endfunction

  function automatic exp_t predict(input logic [31:0] pc, input string name);
    exp_t e;
    int unsigned i = idx_of(pc);
    e.name   = name;
    e.hit    = m_valid[i] && (m_tag[i] == tag_of(pc));
    e.taken  = e.hit && (m_cnt[i] >= CWEAK);
    e.target = e.taken ? m_tgt[i] : pc + 32'd4;
    e.perf   = m_perf[31:0];
    return e;
  endfunction

  function automatic void model_update(input bit uv, input logic [31:0] upc, input bit ut,
                                       input logic [31:0] utgt, input bit uj, input bit um,
                                       input bit fl);
    int unsigned i = idx_of(upc);
    bit hit = m_valid[i] && (m_tag[i] == tag_of(upc));
    if (uv && um && m_perf < 64'hFFFF_FFFF) m_perf = m_perf + 1;
    if (fl) begin
      for (int k = 0; k < ENTRIES; k++) m_valid[k] = 0;
      return;
    end
    if (!uv) return;
    if (hit) begin
      if (uj) begin
        m_cnt[i] = CMAX; m_tgt[i] = utgt;
      end else if (ut) begin
        m_cnt[i] = (m_cnt[i] < CMAX) ? m_cnt[i] + 1 : CMAX; m_tgt[i] = utgt;
      end else begin
        m_cnt[i] = (m_cnt[i] > 0) ? m_cnt[i] - 1 : 0;
      end
    end else if (ut || uj) begin
      m_valid[i] = 1; m_tag[i] = tag_of(upc); m_tgt[i] = utgt;
      m_cnt[i] = uj ? CMAX : CWEAK;
    end
  endfunction

  // One cycle: drive inputs, queue the prediction, then advance the model at the edge.
  task automatic step(input logic [31:0] lpc, input bit uv, input logic [31:0] upc,
                      input bit ut, input logic [31:0] utgt, input bit uj, input bit um,
                      input bit fl, input string name);
    lookup_pc = lpc; upd_valid = uv; upd_pc = upc; upd_taken = ut;
    upd_target = utgt; upd_is_jump = uj; upd_mispredict = um; flush_all = fl;
    exp_q.push_back(predict(lpc, name));
    @(posedge clk);
    if (reset) model_reset();
    else model_update(uv, upc, ut, utgt, uj, um, fl);
    #1;
  endtask

  task automatic look(input logic [31:0] lpc, input string name);
    step(lpc, 0, 32'h0, 0, 32'h0, 0, 0, 0, name);
  endtask

  task automatic train(input logic [31:0] lpc, input logic [31:0] upc, input bit ut,
                       input logic [31:0] utgt, input bit uj, input string name);
    step(lpc, 1, upc, ut, utgt, uj, 0, 0, name);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check({e.name, ".hit"},    {31'd0, pred_hit},   {31'd0, e.hit});
        check({e.name, ".taken"},  {31'd0, pred_taken}, {31'd0, e.taken});
        check({e.name, ".target"}, pred_target,         e.target);
        check({e.name, ".perf"},   perf_mispredicts,    e.perf);
      end
    end
  end

  initial begin : driver
    logic [31:0] pc_a, pc_b, tgt;
    model_reset();
    reset = 1'b1;
    lookup_pc = 32'h40; upd_valid = 0; upd_pc = 0; upd_taken = 0; upd_target = 0;
    upd_is_jump = 0; upd_mispredict = 0; flush_all = 0;
    #1;
    look(32'h40, "reset_state");
    reset = 1'b0;

    // Allocation, then counter walk-down and saturation at zero.
    train(32'h40, 32'h40, 1, 32'h100, 0, "alloc_no_bypass");
    train(32'h40, 32'h40, 0, 32'h0, 0, "after_alloc");
    train(32'h40, 32'h40, 0, 32'h0, 0, "after_nt1");
    for (int k = 0; k < 3; k++) train(32'h40, 32'h40, 0, 32'h0, 0, "nt_saturate");
    look(32'h40, "cnt_at_zero");

    // Aliasing on the same index with a different tag.
    look(32'h440, "alias_miss");
    train(32'h440, 32'h440, 1, 32'h500, 0, "alias_alloc");
    look(32'h440, "alias_hit");
    look(32'h40, "alias_evicted");

    // Same-cycle update/lookup, then flush racing an update.
    train(32'h80, 32'h80, 1, 32'h180, 0, "same_cycle");
    look(32'h80, "same_cycle_next");
    train(32'h40, 32'h40, 1, 32'h140, 0, "realloc_40");
    step(32'h80, 1, 32'h40, 1, 32'h150, 0, 0, 1, "flush_with_update");
    look(32'h40, "flushed_40");
    look(32'h80, "flushed_80");

    // Jump allocates strongly taken; one not-taken leaves it predicting taken.
    train(32'h200, 32'h200, 0, 32'h300, 1, "jal_alloc");
    train(32'h200, 32'h200, 0, 32'h0, 0, "jal_strong");
    look(32'h200, "jal_after_nt");
    look(32'hFFFF_FFFE, "pc_wrap");

    // Misprediction counter: one pulse lacks upd_valid.
    for (int k = 0; k < 5; k++)
      step(32'h0, (k != 2), 32'h1000, 0, 32'h0, 0, 1, 0, "perf_pulse");
    look(32'h0, "perf_settle");
    check("perf_four", perf_mispredicts, 32'd4);

    // Saturation: preload all-ones and pulse across the edge.
    force dut.perf_mispredicts = 32'hFFFF_FFFF;
    m_perf = 64'hFFFF_FFFF;
    step(32'h0, 1, 32'h1000, 0, 32'h0, 0, 1, 0, "perf_sat_forced");
    release dut.perf_mispredicts;
    step(32'h0, 1, 32'h1000, 0, 32'h0, 0, 1, 0, "perf_sat_hold");
    look(32'h0, "perf_sat_final");

    // Asynchronous reset in the middle of a pending update.
    lookup_pc = 32'h600; upd_valid = 1; upd_pc = 32'h600; upd_taken = 1;
    upd_target = 32'h700; upd_is_jump = 0; upd_mispredict = 1; flush_all = 0;
    #2 reset = 1'b1;
    #1;
    check("async_rst.hit",    {31'd0, pred_hit},   32'd0);
    check("async_rst.taken",  {31'd0, pred_taken}, 32'd0);
    check("async_rst.target", pred_target,         32'h604);
    check("async_rst.perf",   perf_mispredicts,    32'd0);
    @(posedge clk);
    #1 reset = 1'b0;
    model_reset();
    look(32'h600, "update_discarded");

    // Randomised traffic over a few indices and tags so hits, aliases and evictions mix.
    for (int n = 0; n < 400; n++) begin
      pc_a = ($urandom_range(0, 3) << 6) | ($urandom_range(0, 3) << 2) | $urandom_range(0, 3);
      pc_b = ($urandom_range(0, 3) << 6) | ($urandom_range(0, 3) << 2) | $urandom_range(0, 3);
      if ($urandom_range(0, 3) == 0) pc_a = pc_a | ($urandom << 14);
      tgt = $urandom;
      step(pc_a, ($urandom_range(0, 3) != 0), pc_b, $urandom_range(0, 1), tgt,
           ($urandom_range(0, 5) == 0), $urandom_range(0, 1),
           ($urandom_range(0, 30) == 0), "random");
    end

    @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
